// File: rtl/alu_exec.sv
// ALU execute stage: combinational ALU feeding a 2-entry result FIFO with valid/ready on both sides.
// Define ALU_EXEC_SHIFT_EN to enable sll/srl on ALUControl codes 110/111.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Illegal
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on valid, and flush cancels every transfer in its cycle.

`ifdef ALU_EXEC_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);
`endif

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (ALUControl)
            3'b000: alu_res = SrcA + SrcB;
            3'b001: alu_res = SrcA - SrcB;
            3'b010: alu_res = SrcA & SrcB;
            3'b011: alu_res = SrcA | SrcB;
            3'b100: alu_res = SrcA ^ SrcB;
            3'b101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
`ifdef ALU_EXEC_SHIFT_EN
            3'b110: alu_res = SrcA << SrcB[SHW-1:0];
            3'b111: alu_res = SrcA >> SrcB[SHW-1:0];
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    logic [WIDTH-1:0] mem_res [2];
    logic             mem_zero [2];
    logic             mem_ill [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_res[wr_ptr]  <= alu_res;
            mem_zero[wr_ptr] <= (alu_res == '0);
            mem_ill[wr_ptr]  <= alu_ill;
        end
    end

    assign ALUResult = out_valid ? mem_res[rd_ptr]  : '0;
    assign Zero      = out_valid ? mem_zero[rd_ptr] : 1'b0;
    assign Illegal   = out_valid ? mem_ill[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed scenarios plus random traffic, checked by a queue-based model at each negedge.
module tb_alu_exec;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic [2:0]   ALUControl = 3'b000;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] ALUResult;
    logic         Zero;
    logic         Illegal;

    int errors = 0;
    int checks = 0;
    logic [W+1:0] exp_q[$];   // {Illegal, Zero, ALUResult}
    logic         rand_phase = 1'b0;

    alu_exec #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult),
        .Zero(Zero), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    // Reference model written straight from the opcode table.
    function automatic logic [W+1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         ill;
        int           sa, sb;
        ill = 1'b0;
        r   = '0;
        sa  = int'(a);
        sb  = int'(b);
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 1 : 0;
`ifdef ALU_EXEC_SHIFT_EN
            3'd6: r = a << (b % W);
            3'd7: r = a >> (b % W);
`endif
            default: ill = 1'b1;
        endcase
        return {ill, (r == 0), r};
    endfunction

    task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: compares DUT against the model, then advances the model for this edge.
    always @(negedge clk) begin
        int  sz;
        logic acc, pp;
        if (reset) begin
            exp_q.delete();
            check("reset_outputs", {in_ready, out_valid, Illegal, Zero, ALUResult}, {1'b1, 1'b0, {(W+2){1'b0}}});
        end else begin
            sz  = exp_q.size();
            acc = in_valid && (sz < 2) && !flush;
            pp  = (sz != 0) && out_ready && !flush;
            check("in_ready", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, (sz < 2)});
            check("out_valid", {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, (sz != 0)});
            if (sz != 0) check("head", {Illegal, Zero, ALUResult}, exp_q[0]);
            else         check("idle_outputs", {Illegal, Zero, ALUResult}, '0);
            if (flush) exp_q.delete();
            else begin
                if (pp)  void'(exp_q.pop_front());
                if (acc) exp_q.push_back(ref_op(ALUControl, SrcA, SrcB));
            end
        end
    end

    // Present one op and hold it until the block accepts it.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        ALUControl = op; SrcA = a; SrcB = b; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stuck at 0, required 1");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        if (rand_phase) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        out_ready = 1'b1;
        send(3'd0, 32'd5, 32'd7);
        drain();
        send(3'd1, 32'd3, 32'd3);
        send(3'd5, 32'hFFFF_FFFF, 32'd1);
        drain();

        // Back-pressure: third op must wait for space.
        out_ready = 1'b0;
        fork
            begin
                send(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
                send(3'd3, 32'h0000_00F0, 32'h0000_000F);
                send(3'd4, 32'hAAAA_AAAA, 32'h5555_5555);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Simultaneous push and pop at one entry.
        out_ready = 1'b0;
        send(3'd0, 32'd100, 32'd1);
        out_ready = 1'b1;
        send(3'd1, 32'd0, 32'd1);
        out_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Flush while full with an op offered.
        out_ready = 1'b0;
        send(3'd0, 32'd1, 32'd2);
        send(3'd0, 32'd3, 32'd4);
        flush = 1'b1; in_valid = 1'b1; ALUControl = 3'd0; SrcA = 32'd9; SrcB = 32'd9;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        send(3'd6, 32'd1, 32'd4);
        send(3'd7, 32'h8000_0000, 32'd31);
        drain();

        // Asynchronous reset with two entries buffered.
        out_ready = 1'b0;
        send(3'd0, 32'd1, 32'd1);
        send(3'd0, 32'd2, 32'd2);
        #2 reset = 1'b1;
        #1 check("async_reset", {in_ready, out_valid, Illegal, Zero, ALUResult}, {1'b1, 1'b0, {(W+2){1'b0}}});
        @(posedge clk); #1 reset = 1'b0;
        out_ready = 1'b1;
        send(3'd4, 32'h0000_00F0, 32'h0000_00FF);
        drain();

        // Random traffic.
        rand_phase = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : $urandom);
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        end
        rand_phase = 1'b0;
        #2 out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
